// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, bin-order helper and read-FSM state type
// for the fft16_out_reorder block.
//   FFT_N, FFT_LOG2N : transform size and its log2
//   bitrev4()        : 4-bit bit reversal (bit-reversed position -> bin)
//   rd_state_e       : read-side FSM states
package fft16_pkg;

   localparam int FFT_N     = 16;
   localparam int FFT_LOG2N = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } rd_state_e;

   function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] a);
      return {a[0], a[1], a[2], a[3]};
   endfunction

endpackage

// File: rtl/fft16_out_reorder_if.sv
// fft16_out_reorder_if: streaming input and valid/ready output bus of the
// FFT output reorder buffer.
//   in_valid/in_re/in_im      : bit-reversed sample stream, no backpressure
//   out_valid/out_ready       : output handshake
//   out_re/out_im/out_idx/out_last : natural-order word, bin index, frame end
//   overflow                  : sticky dropped-sample flag
//   out_mag                   : |re|+|im|, only with FFT16_OUT_REORDER_MAG_EN
// slave modport = reorder block, master modport = surrounding logic.
interface fft16_out_reorder_if #(
   parameter int WD = 12
);
   import fft16_pkg::*;

   logic                  in_valid;
   logic signed [WD-1:0]  in_re;
   logic signed [WD-1:0]  in_im;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [WD-1:0]  out_re;
   logic signed [WD-1:0]  out_im;
   logic [FFT_LOG2N-1:0]  out_idx;
   logic                  out_last;
   logic                  overflow;

`ifdef FFT16_OUT_REORDER_MAG_EN
   logic [WD:0]           out_mag;

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output out_valid, out_re, out_im, out_idx, out_last, overflow, out_mag
   );

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  out_valid, out_re, out_im, out_idx, out_last, overflow, out_mag
   );
`else
   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output out_valid, out_re, out_im, out_idx, out_last, overflow
   );

   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  out_valid, out_re, out_im, out_idx, out_last, overflow
   );
`endif

endinterface

// File: rtl/fft16_pingpong_ram.sv
// fft16_pingpong_ram: 2 banks x 16 words simple dual-port RAM.
// The MSB of each address selects the bank. Sync write, sync read with
// read enable; the read register is reset and holds when i_rd_en is low.
//   clk, rst              : clock, sync active-high reset (read register only)
//   i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr     : read port
//   o_rd_data             : registered read data
module fft16_pingpong_ram
   import fft16_pkg::*;
#(
   parameter int DW = 24,
   parameter int AW = FFT_LOG2N + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)          r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft16_out_reorder.sv
// fft16_out_reorder: takes the bit-reversed output stream of fft_16 and
// re-emits each 16-sample frame in natural bin order through a ping-pong
// buffer and a one-deep valid/ready output register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fft16_out_reorder_if.slave (input stream, output handshake,
//          bin index, last flag, sticky overflow)
// Optional: define FFT16_OUT_REORDER_MAG_EN to add bus.out_mag = |re|+|im|.
//
// state | meaning
// IDLE  | no full bank at the read pointer yet (a load may still start here)
// DRAIN | emitting bank[rbank] words 0..15
module fft16_out_reorder
   import fft16_pkg::*;
#(
   parameter int WD = 12,
   parameter int N  = FFT_N
) (
   input  logic               clk,
   input  logic               rst,
   fft16_out_reorder_if.slave bus
);

   localparam int AW = $clog2(N) + 1;
   localparam logic [FFT_LOG2N-1:0] LAST_POS = FFT_LOG2N'(FFT_N - 1);

   logic [FFT_LOG2N-1:0] r_wcnt;
   logic [FFT_LOG2N-1:0] r_rcnt;
   logic                 r_wbank;
   logic                 r_rbank;
   logic [1:0]           r_full;
   rd_state_e            r_state;
   rd_state_e            w_state_nxt;
   logic                 r_out_valid;
   logic [FFT_LOG2N-1:0] r_out_idx;
   logic                 r_out_last;
   logic                 r_overflow;
   logic                 w_wr_en;
   logic                 w_drop;
   logic                 w_load;
   logic [2*WD-1:0]      w_rd_data;

   // Both banks occupied: the sample has nowhere to go.
   assign w_drop  = bus.in_valid &&  r_full[r_wbank];
   assign w_wr_en = bus.in_valid && !r_full[r_wbank];

   fft16_pingpong_ram #(.DW(2*WD), .AW(AW)) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr ({r_wbank, bitrev4(r_wcnt)}),
      .i_wr_data ({bus.in_re, bus.in_im}),
      .i_rd_en   (w_load),
      .i_rd_addr ({r_rbank, r_rcnt}),
      .o_rd_data (w_rd_data)
   );

   // The first word is loaded in the same cycle IDLE sees the full flag,
   // which gives valid one edge after the frame's last write.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_full[r_rbank]) begin
               w_state_nxt = DRAIN;
               w_load      = !r_out_valid || bus.out_ready;
            end
         end
         DRAIN: begin
            w_load = !r_out_valid || bus.out_ready;
            if (w_load && r_rcnt == LAST_POS)
               w_state_nxt = r_full[!r_rbank] ? DRAIN : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_wbank     <= 1'b0;
         r_rbank     <= 1'b0;
         r_full      <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_wr_en) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST_POS) begin
               r_full[r_wbank] <= 1'b1;
               r_wbank         <= !r_wbank;
            end
         end

         if (w_drop) r_overflow <= 1'b1;

         // Writer sets full on wbank (not full), reader clears rbank (full):
         // the two flag updates always target different bits.
         if (w_load) begin
            r_rcnt     <= r_rcnt + 1'b1;
            r_out_idx  <= r_rcnt;
            r_out_last <= (r_rcnt == LAST_POS);
            if (r_rcnt == LAST_POS) begin
               r_full[r_rbank] <= 1'b0;
               r_rbank         <= !r_rbank;
            end
         end

         if (w_load)             r_out_valid <= 1'b1;
         else if (bus.out_ready) r_out_valid <= 1'b0;
      end
   end

   // The RAM read register is the output data register.
   assign bus.out_valid = r_out_valid;
   assign bus.out_re    = w_rd_data[2*WD-1:WD];
   assign bus.out_im    = w_rd_data[WD-1:0];
   assign bus.out_idx   = r_out_idx;
   assign bus.out_last  = r_out_last;
   assign bus.overflow  = r_overflow;

`ifdef FFT16_OUT_REORDER_MAG_EN
   // Sign-extend before negating so -2^(WD-1) maps to +2^(WD-1).
   // Derived from the read register, so it changes on the same edge as
   // out_re/out_im and holds with them.
   logic signed [WD:0] w_re_x;
   logic signed [WD:0] w_im_x;
   logic [WD:0]        w_abs_re;
   logic [WD:0]        w_abs_im;

   assign w_re_x   = {w_rd_data[2*WD-1], w_rd_data[2*WD-1:WD]};
   assign w_im_x   = {w_rd_data[WD-1], w_rd_data[WD-1:0]};
   assign w_abs_re = w_re_x[WD] ? $unsigned(-w_re_x) : $unsigned(w_re_x);
   assign w_abs_im = w_im_x[WD] ? $unsigned(-w_im_x) : $unsigned(w_im_x);
   assign bus.out_mag = w_abs_re + w_abs_im;
`endif

endmodule

// File: tb/tb_fft16_out_reorder.sv
module tb_fft16_out_reorder;

   localparam int WD = 12;

   typedef struct {
      logic signed [WD-1:0] re;
      logic signed [WD-1:0] im;
      logic [3:0]           idx;
      logic                 last;
      logic [WD:0]          mag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;
   logic bp_mode  = 1'b0;
   logic cont_mode = 1'b0;

   exp_t                 sb[$];
   logic signed [WD-1:0] fr_re[16];
   logic signed [WD-1:0] fr_im[16];

   always #5 clk = ~clk;

   fft16_out_reorder_if #(.WD(WD)) bus ();

   fft16_out_reorder #(.WD(WD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [3:0] tb_bitrev(input logic [3:0] a);
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[i] = a[3-i];
      return b;
   endfunction

   function automatic logic [WD:0] tb_mag(input logic signed [WD-1:0] re,
                                          input logic signed [WD-1:0] im);
      int a, b;
      a = (re < 0) ? -int'(re) : int'(re);
      b = (im < 0) ? -int'(im) : int'(im);
      return (WD+1)'(a + b);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_ready();
      if (bp_mode) bus.out_ready = ~bus.out_ready;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         step_ready();
      end
   endtask

   task automatic drive_pos(input int n);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_re    = fr_re[tb_bitrev(4'(n))];
      bus.in_im    = fr_im[tb_bitrev(4'(n))];
      step_ready();
   endtask

   task automatic push_frame();
      exp_t e;
      for (int k = 0; k < 16; k++) begin
         e.re   = fr_re[k];
         e.im   = fr_im[k];
         e.idx  = 4'(k);
         e.last = (k == 15);
         e.mag  = tb_mag(fr_re[k], fr_im[k]);
         sb.push_back(e);
      end
   endtask

   // Leaves the 16th sample on the bus, not yet written.
   task automatic send_frame(input int gap);
      for (int n = 0; n < 16; n++) begin
         if (n > 0) idle(gap);
         drive_pos(n);
      end
      push_frame();
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 16; k++) begin
         fr_re[k] = $signed(WD'($urandom));
         fr_im[k] = $signed(WD'($urandom));
      end
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         idle(1);
         k++;
      end
      chk("drain_done", sb.size(), 0);
   endtask

   // Output monitor: scoreboard pop on handshake, hold check while stalled.
   logic [28:0] held;
   logic        prev_stall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic [28:0] cur;
      cur = {bus.out_re, bus.out_im, bus.out_idx, bus.out_last};
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("stall_hold", cur, held);
         if (cont_mode)  chk("cont_valid", bus.out_valid, 1);
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_re",   bus.out_re,   e.re);
               chk("out_im",   bus.out_im,   e.im);
               chk("out_idx",  bus.out_idx,  e.idx);
               chk("out_last", bus.out_last, e.last);
`ifdef FFT16_OUT_REORDER_MAG_EN
               chk("out_mag",  bus.out_mag,  e.mag);
`endif
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held       = cur;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_re",    bus.out_re,    0);
      chk("rst_im",    bus.out_im,    0);
      chk("rst_idx",   bus.out_idx,   0);
      chk("rst_last",  bus.out_last,  0);
      chk("rst_ovf",   bus.overflow,  0);

      // Identity frame and first-word latency
      for (int k = 0; k < 16; k++) begin
         fr_re[k] = WD'(k);
         fr_im[k] = -WD'(k);
      end
      send_frame(0);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("id_lat_pre", bus.out_valid, 0);
      @(negedge clk);
      chk("id_lat_valid", bus.out_valid, 1);
      chk("id_lat_idx",   bus.out_idx,   0);
      wait_drain(100);

      // 100 back-to-back frames
      for (int f = 0; f < 100; f++) begin
         fill_rand();
         send_frame(0);
         if (f == 1) cont_mode = 1'b1;
      end
      idle(16);
      cont_mode = 1'b0;
      chk("b2b_ovf", bus.overflow, 0);
      wait_drain(100);

      // Backpressure: ready toggles, third frame's start is dropped
      bp_mode = 1'b1;
      fill_rand();
      send_frame(0);
      fill_rand();
      send_frame(0);
      @(negedge clk);
      chk("bp_ovf_before", bus.overflow, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_re    = 12'sh5A5;
         bus.in_im    = -12'sh123;
         step_ready();
      end
      idle(1);
      @(negedge clk);
      chk("bp_ovf_set", bus.overflow, 1);
      wait_drain(300);
      chk("bp_ovf_sticky", bus.overflow, 1);
      bp_mode       = 1'b0;
      bus.out_ready = 1'b1;
      idle(2);

      // Reset mid-frame with a stalled word at the output
      bus.out_ready = 1'b0;
      fill_rand();
      fr_re[0] = 12'sd321;
      fr_im[0] = -12'sd77;
      send_frame(0);
      idle(4);
      @(negedge clk);
      chk("pre_rst_valid", bus.out_valid, 1);
      fill_rand();
      for (int n = 0; n < 8; n++) drive_pos(n);
      @(posedge clk); #1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mrst_valid", bus.out_valid, 0);
      chk("mrst_re",    bus.out_re,    0);
      chk("mrst_im",    bus.out_im,    0);
      chk("mrst_idx",   bus.out_idx,   0);
      chk("mrst_last",  bus.out_last,  0);
      chk("mrst_ovf",   bus.overflow,  0);
      bus.out_ready = 1'b1;
      fill_rand();
      send_frame(0);
      wait_drain(100);

      // Gapped input: valid every third cycle
      fill_rand();
      send_frame(2);
      @(negedge clk);
      chk("gap_no_early", bus.out_valid, 0);
      wait_drain(100);

      // Magnitude corner: most negative re/im at position 0, then all zero
      fill_rand();
      fr_re[0] = -12'sd2048;
      fr_im[0] = -12'sd2048;
      send_frame(0);
      for (int k = 0; k < 16; k++) begin
         fr_re[k] = '0;
         fr_im[k] = '0;
      end
      send_frame(0);
      wait_drain(100);
      chk("final_ovf", bus.overflow, 0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
